mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences one instruction over 3–5 states and drives the datapath strobes: PC write enable (the PC register's `en`), IR write, memory write, register-file write, and the ALU/result mux selects.
- Stalls on a memory-ready handshake.
- Counts retired instructions and flags unsupported opcodes.

Parameters:
- WAIT_MEM, 1, 1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored (treated as 1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  synchronous active-high reset, sampled on posedge clk.
- opcode  in  7  instr[6:0] from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_we  out  1  PC write enable = pc_update | (branch & zero).
- ir_we  out  1  latch instruction and old PC.
- adr_src  out  1  0: PC, 1: ALUOut to the memory address.
- mem_we  out  1  data memory write strobe.
- reg_we  out  1  register-file write.
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rd1.
- alu_src_b  out  2  00 rd2, 01 imm, 10 const 4.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state_dbg  out  4  current state encoding.
- retired  out  CNT_W  retired instruction count.

Behaviour:
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable and go to FETCH.
- **Reset:**
  - rst=1 at posedge → state=FETCH, retired=0, illegal=0.
  - rst overrides everything, including mid-instruction or while waiting on mem_ready.
- **Output timing:** outputs are combinational from state, plus mem_ready/zero where noted. All outputs not listed for a state are 0.
- **FETCH:**
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_we=pc_update=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - During a stall PC and IR are not written.
- **DECODE:** alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - other → FETCH with illegal=1 for one cycle; nothing written, not retired.
- **MEMADR:** alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if opcode=0000011, else MEMWRITE.
- **MEMREAD:** adr_src=1, result_src=00. Waits for mem_ready, then → MEMWB.
- **MEMWB:** result_src=01, reg_we=1 → FETCH.
- **MEMWRITE:**
  - adr_src=1, result_src=00, mem_we=1, held high for every cycle in this state.
  - Waits for mem_ready, then → FETCH.
- **EXECR:** alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
- **EXECI:** alu_src_a=10, alu_src_b=01, alu_op=10 → ALUWB.
- **ALUWB:** result_src=00, reg_we=1 → FETCH.
- **BEQ:**
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
  - pc_we=zero → FETCH.
- **JAL:**
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 (PC←target).
  - Then → ALUWB (rd←oldPC+4).
- **Retire counter:**
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Illegal and reset transitions do not count.
- **Cycle counts with mem_ready always 1:** lw 5, sw 4, R/I 4, beq 3, jal 4.
- **Write exclusivity:** reg_we and mem_we are never both 1. pc_we is 1 only in FETCH, JAL, or BEQ with zero=1.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 → state_dbg=0, retired=0; first cycle after release pc_we=1 and ir_we=1.
- R-type (opcode 0110011), mem_ready=1 → state sequence 0,1,6,8,0; reg_we=1 only in ALUWB; retired 0→1 after 4 cycles.
- lw (0000011) with mem_ready=0 for 3 cycles in FETCH and 2 in MEMREAD → state held in each; ir_we/pc_we=0 while stalled; total 10 cycles; retired +1.
- sw (0100011) with 1-cycle stall in MEMWRITE → mem_we=1 for both MEMWRITE cycles; reg_we never 1.
- beq with zero=1, then beq with zero=0 → pc_we=1, then 0, in BEQ; each retires in 3 cycles.
- Opcode 1111111 → DECODE→FETCH, illegal=1 for exactly one cycle, retired unchanged. rst asserted in MEMREAD → next state FETCH, retired=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- main control FSM for the multi-cycle RV32I core.
//
// Steps one instruction through 3 to 5 states. In each state it drives the
// datapath strobes and the mux selects. It stalls FETCH, MEMREAD and MEMWRITE
// on the memory-ready handshake. It also counts retired instructions and
// flags opcodes the core does not support.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   opcode       instr[6:0] from the IR
//   zero         ALU zero flag (used for beq)
//   mem_ready    memory access completes this cycle
//   pc_we        PC enable = pc_update | (branch & zero)
//   ir_we        latch the instruction and the old PC
//   adr_src      memory address select: 0 PC, 1 ALUOut
//   mem_we       data-memory write strobe
//   reg_we       register-file write
//   alu_src_a    00 PC, 01 oldPC, 10 rd1
//   alu_src_b    00 rd2, 01 imm, 10 const 4
//   result_src   00 ALUOut, 01 read data, 10 ALU result
//   alu_op       00 add, 01 sub, 10 funct-decoded
//   illegal      high in the DECODE cycle of an unsupported opcode
//   state_dbg    current state encoding
//   retired      retired-instruction count, wraps modulo 2^CNT_W
module mc_control_fsm #(
  parameter bit WAIT_MEM = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             adr_src,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t state, nxt;
  logic   rdy;        // effective handshake; tied high when not waiting on memory
  logic   legal_op;
  logic   retire_ev;  // this cycle's transition completes an instruction
  logic   pc_update;
  logic   branch;

  assign rdy = WAIT_MEM ? mem_ready : 1'b1;

  always_comb begin
    unique case (opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL: legal_op = 1'b1;
      default:                                       legal_op = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:    nxt = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:              nxt = S_EXECR;
          OP_I:              nxt = S_EXECI;
          OP_BEQ:            nxt = S_BEQ;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      default:    nxt = S_FETCH;  // unused codes 11..15 recover to FETCH
    endcase
  end

  // Retire counter. An illegal opcode returns from DECODE, so it never counts.
  always_comb begin
    retire_ev = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BEQ: retire_ev = 1'b1;
      S_MEMWRITE:              retire_ev = rdy;
      default:                 retire_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            retired <= '0;
    else if (retire_ev) retired <= retired + CNT_W'(1);
  end

  // Output logic
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_we      = 1'b0;
    adr_src    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC. Nothing is written
        // while the fetch is stalled.
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we      = rdy;
        pc_update  = rdy;
      end
      S_DECODE: begin
        // oldPC + imm is precomputed into ALUOut as a branch/jump target
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = ~legal_op;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;  // held for every cycle of the stall
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_we = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        // The PC takes the target from ALUOut. The ALU forms oldPC+4 for rd.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_we     = pc_update | (branch & zero);
  assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. A per-cycle vector table is applied in order.
// Each row's expected values go into a scoreboard queue when the row is
// driven. They are popped and compared at the following negedge.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero, mem_ready;
  logic        pc_we, ir_we, adr_src, mem_we, reg_we, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0]  state_dbg;
  logic [31:0] retired;

  mc_control_fsm #(.WAIT_MEM(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src), .mem_we(mem_we),
    .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .illegal(illegal),
    .state_dbg(state_dbg), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic       pcw, irw, memw, regw, ill;
    int         ret;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  vec_t tbl[$];
  vec_t sb[$];
  // Select field values per state: {adr_src, alu_src_a, alu_src_b, result_src, alu_op}
  logic [8:0] sel_exp [0:10];
  int n_tests = 0, n_fail = 0;

  function automatic vec_t mk(logic r, logic [6:0] op, logic z, logic rdy,
                              logic [3:0] st, logic pcw, logic irw, logic memw,
                              logic regw, logic ill, int ret);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.pcw = pcw;
    v.irw = irw; v.memw = memw; v.regw = regw; v.ill = ill; v.ret = ret;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL row%0d %s: got %0h expected %0h", row, name, got, want);
    end
  endtask

  initial begin
    sel_exp[0]  = {1'b0, 2'b00, 2'b10, 2'b10, 2'b00};
    sel_exp[1]  = {1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
    sel_exp[2]  = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
    sel_exp[3]  = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    sel_exp[4]  = {1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
    sel_exp[5]  = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
    sel_exp[6]  = {1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
    sel_exp[7]  = {1'b0, 2'b10, 2'b01, 2'b00, 2'b10};
    sel_exp[8]  = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    sel_exp[9]  = {1'b0, 2'b10, 2'b00, 2'b00, 2'b01};
    sel_exp[10] = {1'b0, 2'b01, 2'b10, 2'b00, 2'b00};

    //            rst op  z   rdy st  pcw irw memw regw ill ret
    // second reset cycle; first cycle after release
    tbl.push_back(mk(1, RT, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    // R-type: 0,1,6,8
    tbl.push_back(mk(0, RT, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, RT, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RT, 0, 1, 6, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, RT, 0, 1, 8, 0, 0, 0, 1, 0, 0));
    // lw: 3-cycle FETCH stall, 2-cycle MEMREAD stall, 10 cycles in total
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 1, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 0, 3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 1, 3, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, LW, 0, 1, 4, 0, 0, 0, 1, 0, 1));
    // sw: 1-cycle MEMWRITE stall, so mem_we is high for both cycles
    tbl.push_back(mk(0, SW, 0, 1, 0, 1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, SW, 0, 1, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, SW, 0, 1, 2, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, SW, 0, 0, 5, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, SW, 0, 1, 5, 0, 0, 1, 0, 0, 2));
    // beq taken, then not taken
    tbl.push_back(mk(0, BQ, 1, 1, 0, 1, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, BQ, 1, 1, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, BQ, 1, 1, 9, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, BQ, 0, 1, 0, 1, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, BQ, 0, 1, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, BQ, 0, 1, 9, 0, 0, 0, 0, 0, 4));
    // jal
    tbl.push_back(mk(0, JL, 0, 1, 0, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(0, JL, 0, 1, 1, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, JL, 0, 1, 10, 1, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, JL, 0, 1, 8, 0, 0, 0, 1, 0, 5));
    // illegal opcode: one-cycle pulse, not retired
    tbl.push_back(mk(0, BAD, 0, 1, 0, 1, 1, 0, 0, 0, 6));
    tbl.push_back(mk(0, BAD, 0, 1, 1, 0, 0, 0, 0, 1, 6));
    // I-type
    tbl.push_back(mk(0, IT, 0, 1, 0, 1, 1, 0, 0, 0, 6));
    tbl.push_back(mk(0, IT, 0, 1, 1, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, IT, 0, 1, 7, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, IT, 0, 1, 8, 0, 0, 0, 1, 0, 6));
    // lw, then reset asserted while stalled in MEMREAD
    tbl.push_back(mk(0, LW, 0, 1, 0, 1, 1, 0, 0, 0, 7));
    tbl.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, LW, 0, 0, 3, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, LW, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0, 0));

    // First reset cycle: state is unknown until this edge.
    rst = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e;
      rst = tbl[i].rst; opcode = tbl[i].op; zero = tbl[i].z;
      mem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk("state_dbg", i, 32'(state_dbg), 32'(e.st));
      chk("retired",   i, retired,        e.ret);
      chk("strobes",   i, {pc_we, ir_we, mem_we, reg_we, illegal},
                          {e.pcw, e.irw, e.memw, e.regw, e.ill});
      chk("selects",   i, {adr_src, alu_src_a, alu_src_b, result_src, alu_op},
                          sel_exp[e.st]);
      if (reg_we && mem_we) chk("write_excl", i, 1, 0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
